// File: rtl/branch_pkg.sv
// branch_pkg: shared address width, checkpoint entry layout and fall-through increment for the branch resolve unit
package branch_pkg;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] FALL_THRU = ADDR_W'(1);
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ghr;
    logic              pred;
    logic [ADDR_W-1:0] target;
  } ckpt_t;
endpackage

// File: rtl/branch_ckpt_fifo.sv
// branch_ckpt_fifo: in-order checkpoint FIFO (push/pop/flush in, head rdata zeroed when empty, full/empty out)
module branch_ckpt_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign rdata   = empty ? '0 : mem[rd_ptr];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: checkpoints fetch predictions, resolves them at execute into PHT/GHR update, flush/redirect, stall and saturating stats
module branch_resolve_unit #(
  parameter int ADDR_W = branch_pkg::ADDR_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              is_branch_F,
  input  logic [ADDR_W-1:0] InstrAddr_F,
  input  logic [ADDR_W-1:0] ghr_F,
  input  logic              prediction_F,
  input  logic [ADDR_W-1:0] pred_target_F,
  input  logic              resolve_valid,
  input  logic              actual_outcome_E,
  input  logic [ADDR_W-1:0] actual_target_E,
  output logic              update_signal,
  output logic              actual_outcome,
  output logic [ADDR_W-1:0] InstrAddr_E,
  output logic [ADDR_W-1:0] ghr_E,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic              stall_F,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt,
  output logic              underflow_err
);
  import branch_pkg::*;
  ckpt_t wr, hd;
  logic  full, empty, pop, push;
  assign wr = '{pc: InstrAddr_F, ghr: ghr_F, pred: prediction_F, target: pred_target_F};
  assign pop = resolve_valid & ~empty;
  assign push = is_branch_F & ~mispredict;
  assign stall_F = full;
  assign InstrAddr_E = hd.pc;
  assign ghr_E = hd.ghr;
  always_comb begin
    update_signal  = pop;
    actual_outcome = pop & actual_outcome_E;
    mispredict     = pop & ((actual_outcome_E != hd.pred) | (actual_outcome_E & hd.pred & (actual_target_E != hd.target)));
    redirect_addr  = !pop ? '0 : actual_outcome_E ? actual_target_E : hd.pc + FALL_THRU;
  end
  branch_ckpt_fifo #(.W($bits(ckpt_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (mispredict),
    .wdata (wr),
    .rdata (hd),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      branch_cnt    <= '0;
      mispred_cnt   <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (pop && !(&branch_cnt)) branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispredict && !(&mispred_cnt)) mispred_cnt <= mispred_cnt + CNT_W'(1);
      if (resolve_valid && empty) underflow_err <= 1'b1;
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: scoreboard bench with a queue-based reference model for branch_resolve_unit
module tb_branch_resolve_unit;
  localparam int AW = 5, DEPTH = 4, CW = 16;
  logic clk, reset;
  logic is_branch_F, prediction_F, resolve_valid, actual_outcome_E;
  logic [AW-1:0] InstrAddr_F, ghr_F, pred_target_F, actual_target_E;
  logic update_signal, actual_outcome, mispredict, stall_F, underflow_err;
  logic [AW-1:0] InstrAddr_E, ghr_E, redirect_addr;
  logic [CW-1:0] branch_cnt, mispred_cnt;
  branch_resolve_unit #(.ADDR_W(AW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .is_branch_F(is_branch_F), .InstrAddr_F(InstrAddr_F), .ghr_F(ghr_F),
    .prediction_F(prediction_F), .pred_target_F(pred_target_F), .resolve_valid(resolve_valid),
    .actual_outcome_E(actual_outcome_E), .actual_target_E(actual_target_E), .update_signal(update_signal),
    .actual_outcome(actual_outcome), .InstrAddr_E(InstrAddr_E), .ghr_E(ghr_E), .mispredict(mispredict),
    .redirect_addr(redirect_addr), .stall_F(stall_F), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt),
    .underflow_err(underflow_err)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  typedef struct { logic [AW-1:0] pc, ghr; logic pred; logic [AW-1:0] tgt; } ent_t;
  typedef struct { logic [AW-1:0] pc, ghr, redir; logic mp, out; } exp_t;
  ent_t q[$];
  exp_t sb[$];
  int bc, mc, e_bc, e_mc, vectors, miscompares;
  bit uf, e_uf, e_upd, e_stall;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic cyc(bit br, logic [AW-1:0] pc, logic [AW-1:0] g, bit p, logic [AW-1:0] t, bit rv, bit a, logic [AW-1:0] at);
    bit stall, pop, mp;
    ent_t h;
    @(posedge clk);
    #1;
    is_branch_F = br; InstrAddr_F = pc; ghr_F = g; prediction_F = p; pred_target_F = t;
    resolve_valid = rv; actual_outcome_E = a; actual_target_E = at;
    stall = q.size() == DEPTH;
    pop = rv && q.size() > 0;
    e_stall = stall; e_bc = bc; e_mc = mc; e_uf = uf; e_upd = pop;
    mp = 0;
    if (pop) begin
      h = q[0];
      mp = (a != h.pred) || (a && h.pred && at != h.tgt);
      sb.push_back('{pc: h.pc, ghr: h.ghr, redir: a ? at : h.pc + 5'd1, mp: mp, out: a});
      if (bc < 65535) bc++;
      if (mp && mc < 65535) mc++;
    end
    if (rv && q.size() == 0) uf = 1;
    if (mp) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (br && !stall) q.push_back('{pc, g, p, t});
    end
  endtask
  task automatic idle_inputs();
    is_branch_F = 0; InstrAddr_F = 0; ghr_F = 0; prediction_F = 0; pred_target_F = 0;
    resolve_valid = 0; actual_outcome_E = 0; actual_target_E = 0;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2;
    idle_inputs();
    reset = 0;
    #1;
    chk("rst_update", update_signal, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_outcome", actual_outcome, 0);
    chk("rst_redirect", redirect_addr, 0);
    chk("rst_pc", InstrAddr_E, 0);
    chk("rst_ghr", ghr_E, 0);
    chk("rst_stall", stall_F, 0);
    chk("rst_branch_cnt", branch_cnt, 0);
    chk("rst_mispred_cnt", mispred_cnt, 0);
    chk("rst_underflow", underflow_err, 0);
    q.delete(); sb.delete();
    bc = 0; mc = 0; uf = 0;
    e_bc = 0; e_mc = 0; e_uf = 0; e_upd = 0; e_stall = 0;
    @(posedge clk);
    #1 reset = 1;
  endtask
  always @(negedge clk) if (reset) begin
    exp_t e;
    chk("update_signal", update_signal, e_upd);
    chk("stall_F", stall_F, e_stall);
    chk("branch_cnt", branch_cnt, e_bc);
    chk("mispred_cnt", mispred_cnt, e_mc);
    chk("underflow_err", underflow_err, e_uf);
    if (update_signal) begin
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL scoreboard: got update_signal with no expected resolution at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("InstrAddr_E", InstrAddr_E, e.pc);
        chk("ghr_E", ghr_E, e.ghr);
        chk("mispredict", mispredict, e.mp);
        chk("redirect_addr", redirect_addr, e.redir);
        chk("actual_outcome", actual_outcome, e.out);
      end
    end else begin
      chk("idle_mispredict", mispredict, 0);
      chk("idle_redirect", redirect_addr, 0);
      chk("idle_outcome", actual_outcome, 0);
    end
  end
  initial begin
    bit a;
    logic [AW-1:0] at;
    reset = 1;
    idle_inputs();
    do_reset();
    cyc(1, 5, 3, 1, 12, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 12);
    cyc(1, 31, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 31, 0, 1, 4, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 5'(i), 5'(i), 1, 5'(i + 8), 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 8);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 20, 1, 1, 3, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    cyc(1, 10, 2, 1, 7, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 9);
    cyc(1, 14, 6, 0, 0, 0, 0, 0);
    cyc(1, 15, 7, 1, 2, 0, 0, 0);
    do_reset();
    cyc(1, 9, 4, 1, 17, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 1, 17);
    for (int i = 0; i < 400; i++) begin
      a = 1'($urandom);
      at = 5'($urandom);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 1) == 1) a = q[0].pred;
        if ($urandom_range(0, 1) == 1) at = q[0].tgt;
      end
      cyc(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
          $urandom_range(0, 2) == 0, a, at);
    end
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
